// File: rtl/ref_clk_en_gen.sv
// ----------------------------------------------------------------------------
// ref_clk_en_gen
//
// Turns the asynchronous reference clock pin into the single-cycle
// referenceClkEn strobe used by the digitalPLL phase comparator. The block
// does four things:
//   - synchronises the pin and detects its rising edges;
//   - applies a programmable prescaler to those edges;
//   - measures the edge-to-edge period in clk cycles;
//   - runs a loss-of-reference watchdog.
// Everything runs on the single PLL clk domain.
//
// Ports
//   clk            in   PLL/system clock
//   resetN         in   asynchronous active-low reset
//   refClkIn       in   raw reference clock pin, asynchronous to clk
//   enable         in   block enable (level)
//   refDivider     in   prescale N; 0 and 1 both divide by 1
//   timeoutCycles  in   loss-of-reference limit in clk cycles; 0 disables it
//   referenceClkEn out  1-clk strobe, one per N reference rising edges
//   refPresent     out  reference qualified as present
//   refPeriod      out  last measured edge-to-edge period in clk cycles
//   periodValid    out  1-clk pulse when refPeriod updates
// ----------------------------------------------------------------------------
module ref_clk_en_gen #(
  parameter int SYNC_STAGES = 3,
  parameter int DIV_WIDTH   = 8,
  parameter int TMR_WIDTH   = 20
) (
  input  logic                 clk,
  input  logic                 resetN,
  input  logic                 refClkIn,
  input  logic                 enable,
  input  logic [DIV_WIDTH-1:0] refDivider,
  input  logic [TMR_WIDTH-1:0] timeoutCycles,
  output logic                 referenceClkEn,
  output logic                 refPresent,
  output logic [TMR_WIDTH-1:0] refPeriod,
  output logic                 periodValid
);

  localparam logic [TMR_WIDTH-1:0] TMR_MAX = '1;

  // Saturating increment for the period timer.
  function automatic logic [TMR_WIDTH-1:0] sat_inc(input logic [TMR_WIDTH-1:0] v);
    return (v == TMR_MAX) ? v : v + TMR_WIDTH'(1);
  endfunction

  // Reload value max(N,1)-1, so that N=0 behaves like N=1.
  function automatic logic [DIV_WIDTH-1:0] div_reload(input logic [DIV_WIDTH-1:0] n);
    return (n == '0) ? '0 : n - DIV_WIDTH'(1);
  endfunction

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   sync_out;
  logic                   prev_p0;
  logic                   edge_p1;

  logic [DIV_WIDTH-1:0]   div_count;
  logic [TMR_WIDTH-1:0]   timer;
  logic                   have_prev;
  logic                   timer_sat;
  logic                   timeout_hit;

  assign sync_out    = sync_p0[SYNC_STAGES-1];
  assign timer_sat   = (timer == TMR_MAX);
  assign timeout_hit = (timeoutCycles != '0) && (timer >= timeoutCycles);

  // ---- stage p0/p1: synchroniser, previous sample, registered rising edge --
  // This front end ignores enable. A reference edge that arrives while the
  // block is disabled is therefore already in flight when enable returns.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      sync_p0 <= '0;
      prev_p0 <= 1'b0;
      edge_p1 <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], refClkIn};
      prev_p0 <= sync_out;
      edge_p1 <= sync_out & ~prev_p0;
    end
  end

  // ---- stage p2: prescaler, period timer, watchdog and registered outputs --
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      referenceClkEn <= 1'b0;
      refPresent     <= 1'b0;
      refPeriod      <= '0;
      periodValid    <= 1'b0;
      div_count      <= '0;
      timer          <= '0;
      have_prev      <= 1'b0;
    end else if (!enable) begin
      // Disabled: drop the strobes and qualification, and clear the count so
      // that the first edge after re-enable strobes. refPeriod keeps its value.
      referenceClkEn <= 1'b0;
      periodValid    <= 1'b0;
      refPresent     <= 1'b0;
      div_count      <= '0;
      have_prev      <= 1'b0;
      timer          <= '0;
    end else begin
      referenceClkEn <= 1'b0;
      periodValid    <= 1'b0;
      if (edge_p1) begin
        // An edge takes precedence over a watchdog timeout in the same cycle.
        timer     <= TMR_WIDTH'(1);
        have_prev <= 1'b1;
        if (div_count == '0) begin
          referenceClkEn <= 1'b1;
          div_count      <= div_reload(refDivider);
        end else begin
          div_count <= div_count - DIV_WIDTH'(1);
        end
        if (have_prev) begin
          refPresent <= 1'b1;
          // A saturated timer means the true period is unknown.
          if (!timer_sat) begin
            refPeriod   <= timer;
            periodValid <= 1'b1;
          end
        end
      end else begin
        timer <= sat_inc(timer);
        if (timeout_hit) begin
          refPresent <= 1'b0;
          have_prev  <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ref_clk_en_gen.sv
// ----------------------------------------------------------------------------
// tb_ref_clk_en_gen
//
// Self-checking bench for ref_clk_en_gen.
//   - A reference model follows the rules in terms of sampled pin history,
//     "clk cycles since the last edge" and "edges left until the next
//     strobe". Every output is compared against it on every falling clk edge.
//   - Directed scenarios check the headline numbers explicitly: latency,
//     strobe spacing, timeout delay, saturation and reset.
//   - A randomized phase then varies the period, divider, timeout and enable.
// TMR_WIDTH is reduced to 10 so that timer saturation can be reached quickly.
// ----------------------------------------------------------------------------
module tb_ref_clk_en_gen;

  localparam int     S    = 3;
  localparam int     DW   = 8;
  localparam int     TW   = 10;
  localparam longint TMAX = (64'd1 << TW) - 1;

  logic          clk;
  logic          resetN;
  logic          refClkIn;
  logic          enable;
  logic [DW-1:0] refDivider;
  logic [TW-1:0] timeoutCycles;
  logic          referenceClkEn;
  logic          refPresent;
  logic [TW-1:0] refPeriod;
  logic          periodValid;

  ref_clk_en_gen #(
    .SYNC_STAGES (S),
    .DIV_WIDTH   (DW),
    .TMR_WIDTH   (TW)
  ) dut (
    .clk            (clk),
    .resetN         (resetN),
    .refClkIn       (refClkIn),
    .enable         (enable),
    .refDivider     (refDivider),
    .timeoutCycles  (timeoutCycles),
    .referenceClkEn (referenceClkEn),
    .refPresent     (refPresent),
    .refPeriod      (refPeriod),
    .periodValid    (periodValid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Inputs change at negedge+1, the pin generator at negedge+3, and the
  // checker samples at negedge. All of these are away from the active edge.
  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // ---------------- reference pin generator ----------------
  int ref_period;  // 0: pin follows man_level
  bit man_level;
  int phase;

  initial begin
    refClkIn = 1'b0;
    phase    = -1;
    forever begin
      @(negedge clk);
      #3;
      if (ref_period == 0) begin
        phase    = -1;
        refClkIn = man_level;
      end else begin
        // A restart from phase -1 rises immediately. Later rises are exactly
        // ref_period clk cycles apart.
        phase    = (phase + 1) % ref_period;
        refClkIn = (phase < ref_period / 2);
      end
    end
  end

  // ---------------- reference model ----------------
  bit     hist [0:S+2];   // hist[k] = pin sampled k clk edges ago
  int     cyc        = 0;
  longint origin     = 1; // elapsed-since-edge = cyc - origin (saturated)
  int     edges_left = 0; // further edges before the next strobe
  bit     have_prev  = 0;
  bit     m_present  = 0;
  bit     m_strobe   = 0;
  bit     m_pv       = 0;
  longint m_period   = 0;
  bit     m_ev;
  longint m_el;

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!resetN) begin
        for (int k = 0; k <= S + 2; k++) hist[k] = 1'b0;
        origin     = cyc + 1;
        edges_left = 0;
        have_prev  = 0;
        m_present  = 0;
        m_strobe   = 0;
        m_pv       = 0;
        m_period   = 0;
      end else begin
        for (int k = S + 2; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = refClkIn;
        // A rise sampled at edge c is acted on at edge c+S+1.
        m_ev     = hist[S+1] && !hist[S+2];
        m_strobe = 0;
        m_pv     = 0;
        if (!enable) begin
          m_present  = 0;
          edges_left = 0;
          have_prev  = 0;
          origin     = cyc + 1;
        end else begin
          m_el = cyc - origin;
          if (m_el > TMAX) m_el = TMAX;
          if (m_ev) begin
            if (have_prev) begin
              m_present = 1;
              if (m_el < TMAX) begin
                m_period = m_el;
                m_pv     = 1;
              end
            end
            if (edges_left == 0) begin
              m_strobe   = 1;
              edges_left = (refDivider > 1) ? int'(refDivider) - 1 : 0;
            end else begin
              edges_left--;
            end
            have_prev = 1;
            origin    = cyc;
          end else if (timeoutCycles != 0 && m_el >= longint'(timeoutCycles)) begin
            m_present = 0;
            have_prev = 0;
          end
        end
      end
    end
  end

  // ---------------- per-cycle comparison against the model ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (!resetN) begin
        check_val("m_strobe_rst",  referenceClkEn, 0);
        check_val("m_present_rst", refPresent,     0);
        check_val("m_pv_rst",      periodValid,    0);
        check_val("m_period_rst",  refPeriod,      0);
      end else begin
        check_val("m_strobe",  referenceClkEn, m_strobe);
        check_val("m_present", refPresent,     m_present);
        check_val("m_pv",      periodValid,    m_pv);
        check_val("m_period",  refPeriod,      32'(m_period));
      end
    end
  end

  task automatic wait_strobe(input int lim, input string tag);
    bit found;
    found = 0;
    for (int n = 0; n < lim; n++) begin
      tick();
      if (referenceClkEn) begin
        found = 1;
        break;
      end
    end
    check_val({tag, "_seen"}, found, 1);
  endtask

  // ---------------- directed scenarios and random phase ----------------
  int t_a;
  int t_b;
  int cnt;
  bit found;
  int lat;

  initial begin
    resetN        = 1'b0;
    enable        = 1'b0;
    refDivider    = 8'd1;
    timeoutCycles = '0;
    ref_period    = 0;
    man_level     = 0;
    repeat (3) tick();
    check_val("rst_strobe",  referenceClkEn, 0);
    check_val("rst_present", refPresent,     0);
    check_val("rst_pv",      periodValid,    0);
    check_val("rst_period",  refPeriod,      0);

    // N=1, period 10
    resetN     = 1'b1;
    enable     = 1'b1;
    ref_period = 10;
    wait_strobe(40, "t1_s0");
    t_a = cyc;
    wait_strobe(40, "t1_s1");
    check_val("t1_spacing", cyc - t_a,   10);
    check_val("t1_pv",      periodValid, 1);
    check_val("t1_period",  refPeriod,   10);
    check_val("t1_present", refPresent,  1);
    tick();
    check_val("t1_pv_one_clk", periodValid, 0);

    // N=4, then N=2 written mid-count
    refDivider = 8'd4;
    wait_strobe(60, "t2_s0");
    t_a = cyc;
    wait_strobe(60, "t2_s1");
    check_val("t2_gap40", cyc - t_a, 40);
    t_a = cyc;
    refDivider = 8'd2;
    wait_strobe(60, "t2_s2");
    check_val("t2_gap_after_write", cyc - t_a, 40);
    t_a = cyc;
    wait_strobe(60, "t2_s3");
    check_val("t2_gap20", cyc - t_a, 20);

    // Watchdog at 25 clk, then recovery
    refDivider    = 8'd1;
    timeoutCycles = 10'd25;
    wait_strobe(60, "t3_s0");
    wait_strobe(60, "t3_s1");
    t_a = cyc;
    check_val("t3_present_before", refPresent, 1);
    ref_period = 0;
    man_level  = 0;
    found = 0;
    t_b   = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (referenceClkEn) t_a = cyc;
      if (!refPresent) begin
        found = 1;
        t_b   = cyc;
        break;
      end
    end
    check_val("t3_lost_seen",  found,     1);
    check_val("t3_lost_delay", t_b - t_a, 25);
    ref_period = 10;
    wait_strobe(60, "t3_r0");
    check_val("t3_r0_pv",      periodValid, 0);
    check_val("t3_r0_present", refPresent,  0);
    wait_strobe(60, "t3_r1");
    check_val("t3_r1_pv",      periodValid, 1);
    check_val("t3_r1_present", refPresent,  1);
    check_val("t3_r1_period",  refPeriod,   10);

    // enable low mid-stream, then re-enable with N=4
    refDivider    = 8'd4;
    timeoutCycles = '0;
    wait_strobe(60, "t4_s0");
    check_val("t4_present_before", refPresent, 1);
    enable = 1'b0;
    tick();
    check_val("t4_off_strobe",  referenceClkEn, 0);
    check_val("t4_off_present", refPresent,     0);
    check_val("t4_off_pv",      periodValid,    0);
    cnt = 0;
    repeat (30) begin
      tick();
      if (referenceClkEn) cnt++;
    end
    check_val("t4_no_strobe_while_off", cnt,       0);
    check_val("t4_period_held",         refPeriod, 10);
    enable = 1'b1;
    wait_strobe(15, "t4_first_after_en");

    // timeoutCycles=0 with a gap longer than the timer range
    refDivider = 8'd1;
    wait_strobe(60, "t6_s0");
    wait_strobe(60, "t6_s1");
    check_val("t6_present_before", refPresent, 1);
    check_val("t6_period_before",  refPeriod,  10);
    ref_period = 0;
    man_level  = 0;
    cnt = 0;
    repeat (1200) begin
      tick();
      if (!refPresent) cnt++;
    end
    check_val("t6_present_held", cnt, 0);
    ref_period = 10;
    wait_strobe(60, "t6_r0");
    check_val("t6_r0_pv",      periodValid, 0);
    check_val("t6_r0_present", refPresent,  1);
    check_val("t6_r0_period",  refPeriod,   10);
    wait_strobe(60, "t6_r1");
    check_val("t6_r1_pv",     periodValid, 1);
    check_val("t6_r1_period", refPeriod,   10);

    // Asynchronous reset mid-count, then first-strobe latency
    refDivider = 8'd4;
    wait_strobe(60, "t5_s0");
    repeat (7) tick();
    check_val("t5_present_before", refPresent, 1);
    resetN = 1'b0;
    #1;
    check_val("t5_async_strobe",  referenceClkEn, 0);
    check_val("t5_async_present", refPresent,     0);
    check_val("t5_async_pv",      periodValid,    0);
    check_val("t5_async_period",  refPeriod,      0);
    repeat (3) tick();
    ref_period = 0;
    man_level  = 0;
    tick();
    resetN = 1'b1;
    repeat (6) tick();
    man_level = 1;
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      tick();
      if (referenceClkEn) begin
        lat = n;
        break;
      end
    end
    // One clk edge samples the pin high; the strobe comes SYNC_STAGES+1
    // edges after that.
    check_val("t5_latency", lat, S + 2);
    man_level = 0;
    repeat (5) tick();

    // Randomized period, divider, timeout and enable activity
    for (int it = 0; it < 12; it++) begin
      int run;
      ref_period    = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(2, 30));
      refDivider    = DW'($urandom_range(0, 5));
      timeoutCycles = ($urandom_range(0, 2) == 0) ? '0 : TW'($urandom_range(3, 70));
      run           = int'($urandom_range(60, 250));
      repeat (run) begin
        tick();
        if ($urandom_range(0, 49) == 0) enable = ~enable;
      end
    end
    enable = 1'b1;
    repeat (5) tick();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
